// File: rtl/bus_link.sv
// bus_link: point-to-point write link between a bus master and a slave register.
// A request (wr & en) seen in IDLE captures data_in into data_out. The link then
// returns a one-cycle rd acknowledge and counts the transfer. A request that is
// held past the acknowledge is parked in WAIT_REL, so it is never captured twice.
//
// Handshake: the master presents a request by holding wr & en high with data_in
// valid. The word is taken on the first rising edge in IDLE that sees the
// request. rd is high for exactly the one cycle after that edge. The master must
// drop the request (wr & en = 0) for at least one edge before the next word is
// accepted.
module bus_link #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic                 en,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 rd,
  output logic [WIDTH-1:0]     data_out,
  output logic [CNT_WIDTH-1:0] xfer_count,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 rd_q, rd_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 req;

  assign req = wr & en;

  // Next-state, capture and counter logic. rd and busy are derived from the
  // next state so that they line up with the registered state.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACK;
          data_d  = data_in;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ACK: begin
        state_d = req ? WAIT_REL : IDLE;
      end
      WAIT_REL: begin
        if (!req) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rd_d   = (state_d == ACK);
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset wins over any pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rd         = rd_q;
  assign busy       = busy_q;
  assign data_out   = data_q;
  assign xfer_count = cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_bus_link.sv
// Directed bench for bus_link: reset, single transfer, held request, ignored
// half-requests, reset mid-transfer, and counter wrap on a narrow-counter copy.
module tb_bus_link;

  localparam int W       = 8;
  localparam int CW      = 16;
  localparam int CW_S    = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic          clk;
  logic          rst, wr, en;
  logic [W-1:0]  data_in;
  logic          rd, busy;
  logic [W-1:0]  data_out;
  logic [CW-1:0] xfer_count;
  logic [1:0]    state_dbg;

  logic            rst_s, wr_s, en_s;
  logic [W-1:0]    data_in_s;
  logic            rd_s, busy_s;
  logic [W-1:0]    data_out_s;
  logic [CW_S-1:0] xfer_count_s;
  logic [1:0]      state_dbg_s;

  int checks = 0;
  int errors = 0;
  int rd_pulses;

  bus_link #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .wr(wr), .en(en), .data_in(data_in),
    .rd(rd), .data_out(data_out), .xfer_count(xfer_count),
    .busy(busy), .state_dbg(state_dbg)
  );

  bus_link #(.WIDTH(W), .CNT_WIDTH(CW_S)) dut_s (
    .clk(clk), .rst(rst_s), .wr(wr_s), .en(en_s), .data_in(data_in_s),
    .rd(rd_s), .data_out(data_out_s), .xfer_count(xfer_count_s),
    .busy(busy_s), .state_dbg(state_dbg_s)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge; inputs and samples happen 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; en = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // one complete transfer on the narrow-counter instance
  task automatic xfer_s(input logic [W-1:0] d);
    wr_s = 1'b1; en_s = 1'b1; data_in_s = d;
    step();
    wr_s = 1'b0; en_s = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; en = 1'b0; data_in = '0;
    rst_s = 1'b1; wr_s = 1'b0; en_s = 1'b0; data_in_s = '0;

    // 1: reset state
    do_reset();
    check("rst_rd", rd, 0);
    check("rst_data", data_out, 8'h00);
    check("rst_cnt", xfer_count, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, S_IDLE);

    // 2: single one-cycle request
    wr = 1'b1; en = 1'b1; data_in = 8'd37;
    step();
    wr = 1'b0; en = 1'b0; data_in = 8'd99;
    check("t2_data", data_out, 8'd37);
    check("t2_rd", rd, 1);
    check("t2_cnt", xfer_count, 1);
    check("t2_busy", busy, 1);
    check("t2_state", state_dbg, S_ACK);
    step();
    check("t2_rd_drop", rd, 0);
    check("t2_state_idle", state_dbg, S_IDLE);
    check("t2_busy_drop", busy, 0);
    check("t2_data_hold", data_out, 8'd37);

    // 3: request held 5 cycles, data_in wiggles while held
    do_reset();
    wr = 1'b1; en = 1'b1; data_in = 8'd12;
    rd_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rd) rd_pulses++;
      data_in = 8'd200 + 8'(i);
    end
    check("t3_pulses", rd_pulses, 1);
    check("t3_data", data_out, 8'd12);
    check("t3_cnt", xfer_count, 1);
    check("t3_state_wait", state_dbg, S_WAIT);
    check("t3_busy_wait", busy, 1);
    en = 1'b0;
    step();
    check("t3_release", state_dbg, S_IDLE);
    check("t3_busy_rel", busy, 0);
    en = 1'b1; data_in = 8'd50;
    step();
    wr = 1'b0; en = 1'b0;
    check("t3_data2", data_out, 8'd50);
    check("t3_cnt2", xfer_count, 2);
    check("t3_rd2", rd, 1);
    step();

    // 4: en without wr, then wr without en, are ignored
    en = 1'b1; wr = 1'b0; data_in = 8'd20;
    rd_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rd) rd_pulses++;
    end
    en = 1'b0; wr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (rd) rd_pulses++;
    end
    wr = 1'b0;
    check("t4_no_rd", rd_pulses, 0);
    check("t4_data", data_out, 8'd50);
    check("t4_cnt", xfer_count, 2);
    check("t4_state", state_dbg, S_IDLE);

    // back-to-back at max rate: request, one idle cycle, request
    wr = 1'b1; en = 1'b1; data_in = 8'hA5;
    step();
    wr = 1'b0;
    check("b2b_data1", data_out, 8'hA5);
    step();
    wr = 1'b1; data_in = 8'h5A;
    step();
    wr = 1'b0; en = 1'b0;
    check("b2b_data2", data_out, 8'h5A);
    check("b2b_rd2", rd, 1);
    check("b2b_cnt", xfer_count, 4);
    step();

    // 5: reset during the ACK cycle aborts the transfer
    wr = 1'b1; en = 1'b1; data_in = 8'd7;
    step();
    check("t5_ack", rd, 1);
    check("t5_data_pre", data_out, 8'd7);
    rst = 1'b1;
    step();
    rst = 1'b0; wr = 1'b0; en = 1'b0;
    check("t5_data", data_out, 8'h00);
    check("t5_rd", rd, 0);
    check("t5_cnt", xfer_count, 0);
    check("t5_busy", busy, 0);
    check("t5_state", state_dbg, S_IDLE);
    step();

    // 6: counter wrap on a 4-bit counter copy (15 transfers -> 0xF, one more -> 0)
    rst_s = 1'b1;
    step(); step();
    rst_s = 1'b0;
    for (int i = 0; i < 15; i++) xfer_s(8'(i + 1));
    check("t6_cnt_max", xfer_count_s, 4'hF);
    check("t6_data_15", data_out_s, 8'd15);
    wr_s = 1'b1; en_s = 1'b1; data_in_s = 8'hC3;
    step();
    wr_s = 1'b0; en_s = 1'b0;
    check("t6_cnt_wrap", xfer_count_s, 4'h0);
    check("t6_rd_wrap", rd_s, 1);
    check("t6_data_wrap", data_out_s, 8'hC3);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
